// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned STAT_W = 16;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Priority pointer after releasing grant_id: the next index, wrapping to 0.
    function automatic int unsigned rr_next(input int unsigned grant_id, input int unsigned num_req);
        return (grant_id + 1 >= num_req) ? 0 : grant_id + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter; master is the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GW         = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          grant_valid;
    logic [GW-1:0]                 grant_id;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_full;

    modport master (
        input  req_valid, req_data, req_last, fifo_wr_full,
        output req_ready, grant_valid, grant_id, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_wr_full,
        input  req_ready, grant_valid, grant_id, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GW      = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      rr_ptr,
    output logic               found,
    output logic [GW-1:0]      idx
);
    int unsigned cand;

    // Scan from the farthest offset down so the nearest hit overwrites earlier ones.
    always_comb begin
        idx   = '0;
        cand  = 0;
        found = |req;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = 32'(rr_ptr) + 32'(k);
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[GW'(cand)]) begin
                idx = GW'(cand);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional FIFO_ARB_STATS_EN adds accepted-word and full-stall counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    fifo_wr_arbiter_if.master           bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]   stat_words,
    output logic [STAT_W-1:0]           stat_full_cyc
`endif
);
    localparam int unsigned GW = id_width(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    arb_state_t            state;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         grant_id;
    logic                  grant_valid;
    logic [BW-1:0]         burst_cnt;

    logic                  pick_found;
    logic [GW-1:0]         pick_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  granted;
    logic                  xfer;
    logic                  pkt_end;
    logic [NUM_REQ-1:0]    req_ready_c;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_picker (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Mux the grant holder's request lines.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_id == GW'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign granted = (state == ARB_GRANT);
    assign xfer    = granted && sel_valid && !bus.fifo_wr_full;
    assign pkt_end = xfer && (sel_last || (burst_cnt == BW'(MAX_BURST - 1)));

    always_comb begin
        req_ready_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (granted && !bus.fifo_wr_full && (grant_id == GW'(i))) begin
                req_ready_c[i] = 1'b1;
            end
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_wr_data = xfer ? sel_data : '0;
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_id     = grant_id;

    // Grant FSM: one arbitration cycle, then hold until packet end or burst limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_idx;
                        grant_valid <= 1'b1;
                        burst_cnt   <= '0;
                        state       <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (pkt_end) begin
                        grant_valid <= 1'b0;
                        rr_ptr      <= GW'(rr_next(32'(grant_id), NUM_REQ));
                        state       <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic full_stall;
    assign full_stall = granted && sel_valid && bus.fifo_wr_full;

    // Saturating per-requester word counters and full-stall cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words    <= '0;
            stat_full_cyc <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (xfer && (grant_id == GW'(i)) && (stat_words[i*STAT_W +: STAT_W] != '1)) begin
                    stat_words[i*STAT_W +: STAT_W] <= stat_words[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
            if (full_stall && (stat_full_cyc != '1)) begin
                stat_full_cyc <= stat_full_cyc + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-fed producers, logged FIFO writes and grants.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned MB = 8;
    localparam int unsigned GW = id_width(NR);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    int unsigned   n_chk = 0;
    int unsigned   n_bad = 0;
    word_t         q [NR][$];
    logic [DW-1:0] wr_log [$];
    logic [DW-1:0] exp_w  [$];
    logic [GW-1:0] gnt_log [$];
    logic [GW-1:0] exp_g  [$];
    logic [NR-1:0] acc;
    logic          gv_prev;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GW(GW)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [NR*STAT_W-1:0] stat_words;
    logic [STAT_W-1:0]    stat_full_cyc;
`endif

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_words    (stat_words),
        .stat_full_cyc (stat_full_cyc)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void drive();
        for (int i = 0; i < int'(NR); i++) begin
            if (q[i].size() != 0) begin
                bus.req_valid[i]            = 1'b1;
                bus.req_data[i*DW +: DW]    = q[i][0].data;
                bus.req_last[i]             = q[i][0].last;
            end else begin
                bus.req_valid[i]            = 1'b0;
                bus.req_data[i*DW +: DW]    = '0;
                bus.req_last[i]             = 1'b0;
            end
        end
    endfunction

    function automatic void push_pkt(input int r, input int n, input logic [DW-1:0] base, input bit with_last);
        for (int k = 0; k < n; k++) begin
            q[r].push_back('{data: base + DW'(k), last: (with_last && (k == n - 1))});
        end
    endfunction

    function automatic bit busy();
        bit b = bus.grant_valid;
        for (int i = 0; i < int'(NR); i++) begin
            if (q[i].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    // One clock: observe at negedge, let the edge act, then pop accepted words and re-drive.
    task automatic cycle();
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        if (bus.fifo_wr_en) wr_log.push_back(bus.fifo_wr_data);
        if (bus.grant_valid && !gv_prev) gnt_log.push_back(bus.grant_id);
        gv_prev = bus.grant_valid;
        if (bus.fifo_wr_full) check_eq("no_write_while_full", bus.fifo_wr_en, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NR); i++) begin
            if (acc[i]) void'(q[i].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n = 0;
        while (busy() && n < max_cyc) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", 64'(busy()), 0);
    endtask

    function automatic void clear_logs();
        wr_log.delete();
        gnt_log.delete();
        exp_w.delete();
        exp_g.delete();
    endfunction

    task automatic check_log(input string tag);
        check_eq({tag, "_words"}, wr_log.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), wr_log[i], exp_w[i]);
        check_eq({tag, "_grants"}, gnt_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < gnt_log.size(); i++)
            check_eq($sformatf("%s_gnt[%0d]", tag, i), gnt_log[i], exp_g[i]);
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.fifo_wr_full = 1'b0;
        gv_prev          = 1'b0;
        acc              = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant_valid", bus.grant_valid, 0);
        check_eq("rst_grant_id", bus.grant_id, 0);
        check_eq("rst_req_ready", bus.req_ready, 0);
        check_eq("rst_wr_en", bus.fifo_wr_en, 0);
        check_eq("rst_wr_data", bus.fifo_wr_data, 0);
        rst = 1'b0;

        // Lone requester 2, three-word packet.
        clear_logs();
        push_pkt(2, 3, 32'h2000_0000, 1);
        drive();
        #1;
        check_eq("t1_idle_gv", bus.grant_valid, 0);
        check_eq("t1_idle_ready", bus.req_ready, 0);
        check_eq("t1_idle_wr_en", bus.fifo_wr_en, 0);
        cycle();
        check_eq("t1_gv", bus.grant_valid, 1);
        check_eq("t1_gid", bus.grant_id, 2);
        check_eq("t1_ready", bus.req_ready, 4'b0100);
        check_eq("t1_wr_en", bus.fifo_wr_en, 1);
        check_eq("t1_wr_data", bus.fifo_wr_data, 32'h2000_0000);
        repeat (3) cycle();
        check_eq("t1_released", bus.grant_valid, 0);
        exp_w = '{32'h2000_0000, 32'h2000_0001, 32'h2000_0002};
        exp_g = '{2'd2};
        check_log("t1");

        // rr_ptr is 3: requester 3 beats requester 0.
        clear_logs();
        push_pkt(0, 1, 32'h0000_00A0, 1);
        push_pkt(3, 1, 32'h3000_00A0, 1);
        drive();
        cycle();
        check_eq("t1_rr_ptr3", bus.grant_id, 3);
        run_until_idle(20);
        exp_w = '{32'h3000_00A0, 32'h0000_00A0};
        exp_g = '{2'd3, 2'd0};
        check_log("t1b");

        // rr_ptr=1: requester 1 streams 20 words, burst limit forces rotation to requester 3.
        clear_logs();
        push_pkt(1, 20, 32'h1000_0000, 1);
        push_pkt(3, 1, 32'h3000_0001, 1);
        drive();
        run_until_idle(60);
        for (int k = 0; k < 8; k++) exp_w.push_back(32'h1000_0000 + 32'(k));
        exp_w.push_back(32'h3000_0001);
        for (int k = 8; k < 20; k++) exp_w.push_back(32'h1000_0000 + 32'(k));
        exp_g = '{2'd1, 2'd3, 2'd1, 2'd1};
        check_log("t3");

        // rr_ptr=2: FIFO full for 5 cycles after two words; burst count must hold.
        clear_logs();
        push_pkt(2, 10, 32'h2000_1000, 1);
        drive();
        repeat (3) cycle();
        bus.fifo_wr_full = 1'b1;
        #1;
        check_eq("t4_full_wr_en", bus.fifo_wr_en, 0);
        check_eq("t4_full_ready", bus.req_ready, 0);
        check_eq("t4_full_gv", bus.grant_valid, 1);
        check_eq("t4_full_gid", bus.grant_id, 2);
        repeat (5) cycle();
        check_eq("t4_full_hold_gv", bus.grant_valid, 1);
        bus.fifo_wr_full = 1'b0;
        #1;
        check_eq("t4_resume_wr_en", bus.fifo_wr_en, 1);
        check_eq("t4_resume_data", bus.fifo_wr_data, 32'h2000_1002);
        repeat (5) cycle();
        check_eq("t4_burst_held", bus.grant_valid, 1);
        cycle();
        check_eq("t4_burst_release", bus.grant_valid, 0);
        run_until_idle(20);
        for (int k = 0; k < 10; k++) exp_w.push_back(32'h2000_1000 + 32'(k));
        exp_g = '{2'd2, 2'd2};
        check_log("t4");

        // rr_ptr=3: asynchronous reset during word 2 of 4 from requester 0.
        clear_logs();
        push_pkt(0, 4, 32'h0000_5000, 1);
        drive();
        repeat (2) cycle();
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_gv", bus.grant_valid, 0);
        check_eq("t5_rst_gid", bus.grant_id, 0);
        check_eq("t5_rst_ready", bus.req_ready, 0);
        check_eq("t5_rst_wr_en", bus.fifo_wr_en, 0);
        check_eq("t5_rst_wr_data", bus.fifo_wr_data, 0);
        cycle();
        for (int i = 0; i < int'(NR); i++) q[i].delete();
        drive();
        rst = 1'b0;
        exp_w = '{32'h0000_5000};
        exp_g = '{2'd0};
        check_log("t5");

        // rr_ptr=0 after reset: all four requesters plus a second packet from 0.
        clear_logs();
        push_pkt(0, 1, 32'hA000_0000, 1);
        push_pkt(1, 1, 32'hB000_0001, 1);
        push_pkt(2, 1, 32'hC000_0002, 1);
        push_pkt(3, 1, 32'hD000_0003, 1);
        push_pkt(0, 1, 32'hA000_0010, 1);
        drive();
        repeat (9) cycle();
        check_eq("t2_last_grant_gv", bus.grant_valid, 1);
        check_eq("t2_last_grant_gid", bus.grant_id, 0);
        cycle();
        check_eq("t2_done_gv", bus.grant_valid, 0);
        exp_w = '{32'hA000_0000, 32'hB000_0001, 32'hC000_0002, 32'hD000_0003, 32'hA000_0010};
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        check_log("t2");

`ifdef FIFO_ARB_STATS_EN
        // Counters: 10 words with 4 stall cycles, then saturation on 70000 words.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("t6_rst_words", stat_words, 0);
        check_eq("t6_rst_full", stat_full_cyc, 0);
        clear_logs();
        push_pkt(0, 10, 32'h6000_0000, 1);
        drive();
        repeat (3) cycle();
        bus.fifo_wr_full = 1'b1;
        repeat (4) cycle();
        bus.fifo_wr_full = 1'b0;
        run_until_idle(40);
        check_eq("t6_words0", stat_words[15:0], 10);
        check_eq("t6_full_cyc", stat_full_cyc, 4);
        push_pkt(1, 70000, 32'h7000_0000, 1);
        drive();
        run_until_idle(90000);
        check_eq("t6_words1_sat", stat_words[31:16], 16'hFFFF);
        check_eq("t6_words0_kept", stat_words[15:0], 10);
        check_eq("t6_full_kept", stat_full_cyc, 4);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
